ysyx_24080006_lsu: RTL
======================

Name: ysyx_24080006_lsu

Overview:
Memory-access stage between EX and WB. It accepts one EX result per handshake and passes non-memory ops through after one register cycle. Loads and stores are issued as single-beat AXI transactions on the LSU-side arbiter port, and load data is aligned and sign/zero-extended. One instruction is in flight at a time, so the stage is a blocking unit that back-pressures EX.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width (only 32 supported)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  EX result valid
in_ready  out  1  LSU can accept
in_load  in  1  op is a load
in_store  in  1  op is a store (in_load&in_store never both 1)
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  32  effective address, or ALU result for non-memory ops
in_wdata  in  32  store data (unshifted)
in_rd  in  5  destination register
in_rd_we  in  1  writes rd
out_valid  out  1  result to WB valid
out_ready  in  1  WB accepts
out_rd  out  5  destination register
out_rd_we  out  1  write enable (forced 0 on error)
out_data  out  32  writeback value
out_err  out  1  misaligned or bus error
araddr  out  32  read address
arsize  out  3  log2 bytes
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  log2 bytes
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  lane-shifted store data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0 except in_ready=1; out_* fields 0; AXI address/data/strb outputs 0.
- FSM states: IDLE, AR, R, WR, B, DONE.
  - IDLE: in_ready=1. On in_valid, latch all inputs, then:
    - misaligned access (H with addr[0]=1, W with addr[1:0]!=0) -> DONE with err=1;
    - load -> AR;
    - store -> WR;
    - otherwise -> DONE with out_data=in_addr.
  - AR: arvalid=1; araddr is the latched address, unmodified. On arready -> R.
  - R: rready=1. On rvalid, capture rdata >> (8*addr[1:0]), extend per funct3, set err=(rresp!=0), then -> DONE.
  - WR: awvalid and wvalid both asserted. Each drops independently after its own handshake; aw_done and w_done flags track completion. Both handshakes may occur in the same cycle. Once both are done -> B.
  - B: bready=1. On bvalid, err=(bresp!=0) and out_data=0, then -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE. in_ready=0 in every state except IDLE, so there is no same-cycle re-accept.
- Store strobes and data: wstrb is 0001/0011/1111 shifted left by addr[1:0]. wdata is wdata shifted left by 8*addr[1:0].
- Sizes: arsize and awsize are 0, 1 or 2, taken from funct3[1:0].
- AXI stability: valid signals are never dropped before their handshake, and addresses and data are held stable while valid.
- Latency:
  - non-memory op and misaligned access: out_valid one cycle after accept;
  - load: out_valid one cycle after the rvalid handshake;
  - store: out_valid one cycle after the bvalid handshake.
- On err, out_rd_we=0. Otherwise out_rd_we=latched rd_we, and stores force it to 0.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any outstanding AXI response is not tracked; the arbiter is reset by the same signal.

Test Plan:
- Non-memory op: addr=0x1234, rd=5, rd_we=1, out_ready=1 -> out_valid one cycle later, out_data=0x1234, no AR or AW activity.
- LB at 0x80000003, rdata=0x80FFFFFF -> araddr=0x80000003, arsize=0, out_data=0xFFFFFF80. Repeat as LBU -> out_data=0x00000080.
- SH at 0x80000002, wdata=0x0000BEEF; aw and w handshakes in different cycles -> wstrb=1100, wdata=0xBEEF0000, awsize=1, one B handshake, out_rd_we=0.
- LW at 0x80000001 -> no arvalid, out_err=1, out_rd_we=0 one cycle after accept.
- Back-pressure: arready low for 5 cycles and out_ready low for 3 cycles -> arvalid/araddr held stable, out_valid held with stable data, in_ready=0 throughout.
- Error and reset: rresp=2'b10 on a load -> out_err=1; separately, reset asserted while in WR -> all valids 0 and in_ready=1 immediately.

Source files
------------

// File: rtl/ysyx_24080006_lsu.sv
// Memory-access stage: passes ALU results through, issues single-beat AXI loads/stores, aligns and extends load data.
// Latency: 1 cycle after accept (non-mem / misaligned); 1 cycle after the R or B handshake for loads / stores.
// Backpressure: blocking unit, one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module ysyx_24080006_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [4:0]          in_rd,
  input  logic                in_rd_we,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          f3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [4:0]          rd_q;
  logic                rd_we_q;
  logic                store_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic                aw_done_q;
  logic                w_done_q;

  logic                accept;
  logic                misalign;
  logic                aw_hs;
  logic                w_hs;
  logic [DATA_W-1:0]   rsh;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W/8-1:0] strb_base;

  assign accept   = in_valid && (state_q == IDLE);
  // Halfwords need addr[0]==0, words need addr[1:0]==0; only memory ops can be misaligned.
  assign misalign = (in_load || in_store) &&
                    (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign rsh      = rdata >> {addr_q[1:0], 3'b000};

  // Size/sign extension of the lane-aligned read data.
  always_comb begin
    load_val = rsh;
    case (f3_q)
      3'b000:  load_val = {{(DATA_W-8){rsh[7]}}, rsh[7:0]};
      3'b001:  load_val = {{(DATA_W-16){rsh[15]}}, rsh[15:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, rsh[7:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, rsh[15:0]};
      default: load_val = rsh;
    endcase
  end

  // Unshifted byte-enable pattern for the access size.
  always_comb begin
    strb_base = '1;
    case (in_funct3[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; WR leaves only once both AW and W have completed (possibly in the same cycle).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (misalign)      state_d = DONE;
        else if (in_load)  state_d = AR;
        else if (in_store) state_d = WR;
        else               state_d = DONE;
      end
      AR:   if (arready) state_d = R;
      R:    if (rvalid)  state_d = DONE;
      WR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = B;
      B:    if (bvalid)  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the op on accept, then capture the response; AXI payload is registered so it is stable while valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      store_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= in_addr;
        f3_q      <= in_funct3;
        wdata_q   <= in_wdata << {in_addr[1:0], 3'b000};
        wstrb_q   <= strb_base << in_addr[1:0];
        rd_q      <= in_rd;
        rd_we_q   <= in_rd_we;
        store_q   <= in_store;
        err_q     <= misalign;
        data_q    <= (in_load || in_store) ? '0 : in_addr;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if ((state_q == R) && rvalid) begin
        data_q <= load_val;
        err_q  <= (rresp != 2'b00);
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if ((state_q == B) && bvalid) begin
        data_q <= '0;
        err_q  <= (bresp != 2'b00);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == R);
  assign awvalid   = (state_q == WR) && !aw_done_q;
  assign wvalid    = (state_q == WR) && !w_done_q;
  assign bready    = (state_q == B);
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = {1'b0, f3_q[1:0]};
  assign awsize    = {1'b0, f3_q[1:0]};
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign out_rd    = rd_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_rd_we = rd_we_q && !err_q && !store_q;

endmodule
